// File: rtl/odd_even_merge_stream_pkg.sv
// Shared definitions for the odd-even merge stream controller:
// controller state encoding and the pad value that sorts to the tail.
package odd_even_merge_stream_pkg;

    // state    | meaning
    // ST_FILL  | collecting input beats into the slot register
    // ST_FIRE  | one-cycle fire pulse to the network
    // ST_WAIT  | waiting for the network result
    // ST_DRAIN | emitting the real elements of the sorted frame
    localparam logic [1:0] ST_FILL  = 2'd0;
    localparam logic [1:0] ST_FIRE  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DRAIN = 2'd3;

    localparam int PAD_MAX_W = 64;

    // Value that loses every comparison in the network's sort direction,
    // so pad slots always end up behind the real elements.
    // Bits above data_width are returned as zero.
    function automatic logic [PAD_MAX_W-1:0] pad_value(
        input int data_width,
        input bit is_signed,
        input bit ascending
    );
        logic [PAD_MAX_W-1:0] p;
        p = '0;
        for (int i = 0; i < PAD_MAX_W; i++) begin
            if (i < data_width) begin
                if (ascending) begin
                    p[i] = !(is_signed && (i == data_width - 1));
                end else begin
                    p[i] = is_signed && (i == data_width - 1);
                end
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/odd_even_merge_stream_watchdog.sv
// Load/count/expire counter bounding the time spent waiting on the network.
// Loaded on the cycle before WAIT; expired_o rises on the LIMIT-th enabled cycle.
module odd_even_merge_stream_watchdog
    import odd_even_merge_stream_pkg::*;
#(
    parameter int LIMIT = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);

    localparam int W = $clog2(LIMIT + 1);
    localparam logic [W-1:0] LOAD_VAL = W'(LIMIT - 1);
    localparam logic [W-1:0] ONE      = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    assign expired_o = en_i && (cnt_q == '0);

    // Next count: reload on entry, otherwise count down while enabled.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = LOAD_VAL;
        end else if (en_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - ONE;
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/odd_even_merge_stream_ctrl.sv
// Sequencing controller for a pipelined odd-even merge sorting network.
// Collects a frame serially, pads short frames, fires the network once,
// captures the sorted vector and drains only the real elements.
// Optional build macro: ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN adds the err
// output and a WAIT watchdog of TIMEOUT_CYCLES cycles.
module odd_even_merge_stream_ctrl
    import odd_even_merge_stream_pkg::*;
#(
    parameter int LOG_INPUT      = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int SIGNED         = 0,
    parameter int ASCENDING      = 1,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [DATA_WIDTH-1:0]               s_data,
    input  logic                                s_valid,
    input  logic                                s_last,
    output logic                                s_ready,
    output logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] net_x,
    output logic                                net_x_valid,
    input  logic [DATA_WIDTH*(2**LOG_INPUT)-1:0] net_y,
    input  logic                                net_y_valid,
    output logic [DATA_WIDTH-1:0]               m_data,
    output logic                                m_valid,
    output logic                                m_last,
    input  logic                                m_ready,
    output logic                                busy
`ifdef ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN
    , output logic                              err
`endif
);

    localparam int N = 2 ** LOG_INPUT;
    localparam logic [PAD_MAX_W-1:0]  PAD_FULL = pad_value(DATA_WIDTH, SIGNED != 0, ASCENDING != 0);
    localparam logic [DATA_WIDTH-1:0] PAD      = PAD_FULL[DATA_WIDTH-1:0];
    localparam logic [LOG_INPUT-1:0]  CNT_ONE  = LOG_INPUT'(1);
    localparam logic [LOG_INPUT-1:0]  CNT_MAX  = '1;
    localparam logic [LOG_INPUT:0]    LEN_ONE  = (LOG_INPUT + 1)'(1);

    if (LOG_INPUT < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("odd_even_merge_stream_ctrl: LOG_INPUT and TIMEOUT_CYCLES must be >= 1");
    end

    logic [1:0]            state_q, state_d;
    logic [LOG_INPUT-1:0]  cnt_q, cnt_d;
    logic [LOG_INPUT-1:0]  idx_q, idx_d;
    logic [LOG_INPUT:0]    len_q, len_d;
    logic [DATA_WIDTH-1:0] x_q [N];
    logic [DATA_WIDTH-1:0] x_d [N];
    logic [DATA_WIDTH-1:0] y_q [N];
    logic [DATA_WIDTH-1:0] y_d [N];
    logic [DATA_WIDTH-1:0] y_in [N];
    logic                  accept;
    logic                  timeout;

    for (genvar k = 0; k < N; k++) begin : g_slots
        assign net_x[DATA_WIDTH*k +: DATA_WIDTH] = x_q[k];
        assign y_in[k] = net_y[DATA_WIDTH*k +: DATA_WIDTH];
    end

`ifdef ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN
    logic err_q;

    odd_even_merge_stream_watchdog #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk       (clk),
        .rst       (rst),
        .load_i    (state_q == ST_FIRE),
        .en_i      (state_q == ST_WAIT),
        .expired_o (timeout)
    );

    // Sticky error flag: a result that arrives on the expiry cycle still wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if ((state_q == ST_WAIT) && timeout && !net_y_valid) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign timeout = 1'b0;
`endif

    // Gated with rst so no beat is taken during the reset cycle.
    assign s_ready     = (state_q == ST_FILL) && !rst;
    assign accept      = s_valid && s_ready;
    assign net_x_valid = (state_q == ST_FIRE);
    assign busy        = (state_q != ST_FILL);
    assign m_valid     = (state_q == ST_DRAIN);
    assign m_last      = m_valid && (({1'b0, idx_q} + LEN_ONE) == len_q);
    assign m_data      = m_valid ? y_q[idx_q] : '0;

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        len_d   = len_q;
        x_d     = x_q;
        y_d     = y_q;
        case (state_q)
            ST_FILL: begin
                if (accept) begin
                    x_d[cnt_q] = s_data;
                    if ((cnt_q == CNT_MAX) || s_last) begin
                        len_d   = {1'b0, cnt_q} + LEN_ONE;
                        cnt_d   = '0;
                        state_d = ST_FIRE;
                        for (int k = 0; k < N; k++) begin
                            if (k > int'(cnt_q)) begin
                                x_d[k] = PAD;
                            end
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end
            ST_FIRE: begin
                state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (net_y_valid) begin
                    y_d     = y_in;
                    idx_d   = '0;
                    state_d = ST_DRAIN;
                end else if (timeout) begin
                    cnt_d   = '0;
                    state_d = ST_FILL;
                end
            end
            ST_DRAIN: begin
                if (m_ready) begin
                    if (m_last) begin
                        idx_d   = '0;
                        cnt_d   = '0;
                        state_d = ST_FILL;
                    end else begin
                        idx_d = idx_q + CNT_ONE;
                    end
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // State, counters and slot registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_FILL;
            cnt_q   <= '0;
            idx_q   <= '0;
            len_q   <= '0;
            for (int k = 0; k < N; k++) begin
                x_q[k] <= '0;
                y_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

endmodule

// File: tb/tb_odd_even_merge_stream_ctrl.sv
// Directed bench: two controllers (unsigned ascending, signed descending),
// N=4, DW=8, each feeding a behavioural 3-cycle-latency sorting network.
module tb_odd_even_merge_stream_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    int   checks   = 0;
    int   failures = 0;

    // unsigned ascending instance
    logic [7:0]  s_data_u;
    logic        s_valid_u, s_last_u, s_ready_u;
    logic [31:0] net_x_u, net_y_u;
    logic        net_x_valid_u, net_y_valid_u;
    logic [7:0]  m_data_u;
    logic        m_valid_u, m_last_u, m_ready_u, busy_u;

    // signed descending instance
    logic [7:0]  s_data_s;
    logic        s_valid_s, s_last_s, s_ready_s;
    logic [31:0] net_x_s, net_y_s;
    logic        net_x_valid_s, net_y_valid_s;
    logic [7:0]  m_data_s;
    logic        m_valid_s, m_last_s, m_ready_s, busy_s;

`ifdef ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN
    logic err_u, err_s;
`endif

    odd_even_merge_stream_ctrl #(
        .LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(0), .ASCENDING(1), .TIMEOUT_CYCLES(5)
    ) dut_u (
        .clk(clk), .rst(rst),
        .s_data(s_data_u), .s_valid(s_valid_u), .s_last(s_last_u), .s_ready(s_ready_u),
        .net_x(net_x_u), .net_x_valid(net_x_valid_u),
        .net_y(net_y_u), .net_y_valid(net_y_valid_u),
        .m_data(m_data_u), .m_valid(m_valid_u), .m_last(m_last_u), .m_ready(m_ready_u),
        .busy(busy_u)
`ifdef ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN
        , .err(err_u)
`endif
    );

    odd_even_merge_stream_ctrl #(
        .LOG_INPUT(2), .DATA_WIDTH(8), .SIGNED(1), .ASCENDING(0), .TIMEOUT_CYCLES(5)
    ) dut_s (
        .clk(clk), .rst(rst),
        .s_data(s_data_s), .s_valid(s_valid_s), .s_last(s_last_s), .s_ready(s_ready_s),
        .net_x(net_x_s), .net_x_valid(net_x_valid_s),
        .net_y(net_y_s), .net_y_valid(net_y_valid_s),
        .m_data(m_data_s), .m_valid(m_valid_s), .m_last(m_last_s), .m_ready(m_ready_s),
        .busy(busy_s)
`ifdef ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN
        , .err(err_s)
`endif
    );

    // Behavioural sorting network: simple bubble sort of four bytes.
    function automatic logic [31:0] net_sort(input logic [31:0] v, input bit sgn, input bit asc);
        logic [7:0]  e [4];
        logic [7:0]  t;
        logic [31:0] r;
        bit          sw;
        for (int k = 0; k < 4; k++) e[k] = v[8*k +: 8];
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (sgn) sw = asc ? ($signed(e[j]) > $signed(e[j+1])) : ($signed(e[j]) < $signed(e[j+1]));
                else     sw = asc ? (e[j] > e[j+1]) : (e[j] < e[j+1]);
                if (sw) begin
                    t = e[j]; e[j] = e[j+1]; e[j+1] = t;
                end
            end
        end
        for (int k = 0; k < 4; k++) r[8*k +: 8] = e[k];
        return r;
    endfunction

    logic        net_en_u = 1'b1;
    logic        stray_u  = 1'b0;
    logic [2:0]  vp_u = '0;
    logic [31:0] dp_u [3];
    logic [2:0]  vp_s = '0;
    logic [31:0] dp_s [3];
    int          fires_u = 0;

    always @(posedge clk) begin
        vp_u     <= {vp_u[1:0], net_x_valid_u & net_en_u};
        dp_u[0]  <= net_sort(net_x_u, 1'b0, 1'b1);
        dp_u[1]  <= dp_u[0];
        dp_u[2]  <= dp_u[1];
        vp_s     <= {vp_s[1:0], net_x_valid_s};
        dp_s[0]  <= net_sort(net_x_s, 1'b1, 1'b0);
        dp_s[1]  <= dp_s[0];
        dp_s[2]  <= dp_s[1];
        if (net_x_valid_u === 1'b1) fires_u <= fires_u + 1;
    end

    assign net_y_valid_u = vp_u[2] | stray_u;
    assign net_y_u       = stray_u ? 32'hDEADBEEF : dp_u[2];
    assign net_y_valid_s = vp_s[2];
    assign net_y_s       = dp_s[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input logic l);
        if (sel) begin
            s_valid_s = 1'b1; s_data_s = d; s_last_s = l;
        end else begin
            s_valid_u = 1'b1; s_data_u = d; s_last_u = l;
        end
        #1;
        check("s_ready_in_fill", sel ? s_ready_s : s_ready_u, 1'b1);
        tick();
        s_valid_u = 1'b0; s_last_u = 1'b0;
        s_valid_s = 1'b0; s_last_s = 1'b0;
    endtask

    task automatic recv(input bit sel, input logic [7:0] d, input logic l, input string tag);
        int n = 0;
        while (!(sel ? m_valid_s : m_valid_u) && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_valid"}, sel ? m_valid_s : m_valid_u, 1'b1);
        check({tag, "_data"},  sel ? m_data_s  : m_data_u,  d);
        check({tag, "_last"},  sel ? m_last_s  : m_last_u,  l);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit observed=expired expected=finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int mv_seen;
        rst = 1'b1;
        s_data_u = '0; s_valid_u = 1'b0; s_last_u = 1'b0; m_ready_u = 1'b1;
        s_data_s = '0; s_valid_s = 1'b0; s_last_s = 1'b0; m_ready_s = 1'b1;
        @(negedge clk);
        tick();

        // reset state
        check("rst_s_ready",     s_ready_u, 1'b0);
        check("rst_net_x_valid", net_x_valid_u, 1'b0);
        check("rst_m_valid",     m_valid_u, 1'b0);
        check("rst_m_last",      m_last_u, 1'b0);
        check("rst_busy",        busy_u, 1'b0);
        check("rst_net_x",       net_x_u, 32'h0);
        check("rst_m_data",      m_data_u, 8'h00);
        check("rst_busy_s",      busy_s, 1'b0);
        rst = 1'b0;
        #1;
        check("post_rst_s_ready", s_ready_u, 1'b1);

        // full frame 9,3,7,1
        send(0, 8'd9, 0); send(0, 8'd3, 0); send(0, 8'd7, 0); send(0, 8'd1, 0);
        check("t1_fire",        net_x_valid_u, 1'b1);
        check("t1_net_x",       net_x_u, 32'h01070309);
        check("t1_busy",        busy_u, 1'b1);
        check("t1_s_ready_off", s_ready_u, 1'b0);
        tick();
        check("t1_fire_once",   net_x_valid_u, 1'b0);
        check("t1_wait_busy",   busy_u, 1'b1);
        recv(0, 8'd1, 0, "t1_b0"); recv(0, 8'd3, 0, "t1_b1");
        recv(0, 8'd7, 0, "t1_b2"); recv(0, 8'd9, 1, "t1_b3");
        check("t1_m_valid_drop", m_valid_u, 1'b0);
        check("t1_busy_low",     busy_u, 1'b0);
        check("t1_s_ready_back", s_ready_u, 1'b1);
        check("t1_fire_count",   fires_u, 1);

        // short frame 5,2 with last on 2
        send(0, 8'd5, 0); send(0, 8'd2, 1);
        check("t2_fire",  net_x_valid_u, 1'b1);
        check("t2_net_x", net_x_u, 32'hFFFF0205);
        recv(0, 8'd2, 0, "t2_b0"); recv(0, 8'd5, 1, "t2_b1");
        check("t2_m_valid_drop", m_valid_u, 1'b0);
        check("t2_busy_low",     busy_u, 1'b0);
        check("t2_fire_count",   fires_u, 2);

        // signed descending frame -3,4 with last
        send(1, 8'hFD, 0); send(1, 8'h04, 1);
        check("t3_fire",  net_x_valid_s, 1'b1);
        check("t3_net_x", net_x_s, 32'h808004FD);
        recv(1, 8'h04, 0, "t3_b0"); recv(1, 8'hFD, 1, "t3_b1");
        check("t3_m_valid_drop", m_valid_s, 1'b0);

        // backpressure 1,0,0,1 with stray y_valid during drain
        send(0, 8'h14, 0); send(0, 8'h0A, 0); send(0, 8'h28, 0); send(0, 8'h1E, 0);
        recv(0, 8'h0A, 0, "t4_b0");
        m_ready_u = 1'b0;
        stray_u   = 1'b1;
        #1;
        check("t4_stall1_data",    m_data_u, 8'h14);
        check("t4_stall1_last",    m_last_u, 1'b0);
        check("t4_stall1_s_ready", s_ready_u, 1'b0);
        tick();
        stray_u = 1'b0;
        #1;
        check("t4_stall2_valid",   m_valid_u, 1'b1);
        check("t4_stall2_data",    m_data_u, 8'h14);
        check("t4_stall2_s_ready", s_ready_u, 1'b0);
        tick();
        check("t4_stall2_hold",    m_data_u, 8'h14);
        m_ready_u = 1'b1;
        recv(0, 8'h14, 0, "t4_b1");
        check("t4_drain_s_ready",  s_ready_u, 1'b0);
        recv(0, 8'h1E, 0, "t4_b2"); recv(0, 8'h28, 1, "t4_b3");
        check("t4_busy_low", busy_u, 1'b0);

        // reset while waiting, late y_valid must be ignored
        send(0, 8'd1, 0); send(0, 8'd2, 0); send(0, 8'd3, 0); send(0, 8'd4, 0);
        tick();
        check("t5_in_wait", busy_u, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("t5_rst_busy",    busy_u, 1'b0);
        check("t5_rst_s_ready", s_ready_u, 1'b1);
        mv_seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_valid_u === 1'b1 || busy_u === 1'b1) mv_seen++;
            tick();
        end
        check("t5_late_y_ignored", mv_seen, 0);
        send(0, 8'd8, 0); send(0, 8'd6, 0); send(0, 8'd4, 0); send(0, 8'd2, 0);
        recv(0, 8'd2, 0, "t5_b0"); recv(0, 8'd4, 0, "t5_b1");
        recv(0, 8'd6, 0, "t5_b2"); recv(0, 8'd8, 1, "t5_b3");

`ifdef ODD_EVEN_MERGE_STREAM_CTRL_TIMEOUT_EN
        // network never responds, watchdog of 5 cycles
        net_en_u = 1'b0;
        check("t6_err_clear", err_u, 1'b0);
        send(0, 8'd1, 0); send(0, 8'd2, 0); send(0, 8'd3, 0); send(0, 8'd4, 0);
        tick();
        for (int i = 1; i <= 5; i++) begin
            check("t6_wait_err", err_u, 1'b0);
            check("t6_wait_busy", busy_u, 1'b1);
            if (i < 5) tick();
        end
        tick();
        check("t6_err_set",    err_u, 1'b1);
        check("t6_fill",       busy_u, 1'b0);
        check("t6_s_ready",    s_ready_u, 1'b1);
        check("t6_no_m_valid", m_valid_u, 1'b0);
        tick();
        check("t6_err_sticky", err_u, 1'b1);
        net_en_u = 1'b1;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
